// File: rtl/serial_tx_if.sv
// Parallel-word handshake and serial-line bundle for serial_tx.
// A word moves on a posedge when din_valid && din_ready. din_valid is ignored while din_ready is low, and din_ready carries no dependency on din_valid.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              tx;
    logic              busy;
    logic [1:0]        state;

    modport master (
        output din, din_valid,
        input  din_ready, tx, busy, state
    );

    modport slave (
        input  din, din_valid,
        output din_ready, tx, busy, state
    );
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit 0, DATA_W data bits LSB first, stop bit 1,
// with each bit held CLKS_PER_BIT clocks. tx and busy are registered from the next state.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic           clk,
    input logic           rst,
    serial_tx_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [BIT_W-1:0]  bit_idx, bit_nx;
    logic [DATA_W-1:0] shift, shift_nx;
    logic              tx_q, tx_nx;
    logic              busy_q, busy_nx;
    logic              period_end;

    assign period_end    = (cnt == CNT_LAST);
    assign bus.din_ready = (state == IDLE);
    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
            tx_q    <= tx_nx;
            busy_q  <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        shift_nx = shift;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.din_valid) begin
                    state_nx = START;
                    cnt_nx   = '0;
                    shift_nx = bus.din;
                end
            end
            START: begin
                if (period_end) begin
                    state_nx = DATA;
                    cnt_nx   = '0;
                    bit_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DATA: begin
                if (period_end) begin
                    cnt_nx   = '0;
                    shift_nx = shift >> 1;
                    if (bit_idx == BIT_LAST) begin
                        state_nx = STOP;
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STOP: begin
                if (period_end) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Output registers load the value belonging to the state being entered.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
        busy_nx = (state_nx != IDLE);
    end
endmodule
